// File: rtl/ruler_job_scheduler.sv
// ruler_job_scheduler: queues Golomb ruler search jobs, runs each one on the mark-counter
// assembly and streams the snapshotted results out tagged with the job id.
module ruler_job_scheduler #(
    parameter int MAXVALUE       = 22,
    parameter int NUMPOSITIONS   = 5,
    parameter int NUMRESULTS     = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1048576,
    localparam int W = (NUMPOSITIONS + 1) * 9
) (
    input  logic                    clock,
    input  logic                    RESET,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [7:0]              job_id,
    input  logic [6:0]              job_fvp,
    input  logic [W-1:0]            job_firstvalues,
    output logic                    asm_reset,
    output logic [6:0]              asm_fvp,
    output logic [W-1:0]            asm_firstvalues,
    input  logic                    asm_done,
    input  logic [5:0]              asm_numResults,
    input  logic [W*NUMRESULTS-1:0] asm_results,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [7:0]              res_id,
    output logic [5:0]              res_index,
    output logic [5:0]              res_count,
    output logic [W-1:0]            res_marks,
    output logic                    res_last,
    output logic                    res_timeout,
    output logic                    busy,
    output logic [15:0]             jobs_completed
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 8 + 7 + W;

    if (MAXVALUE > 511 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RST_CYCLES < 1) begin : g_param_err
        $error("ruler_job_scheduler: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, RST, RUN, SNAP, DRAIN, TOUT} state_t;
    state_t state_q, state_d;

    logic [EW-1:0]           mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           cnt_q;
    logic [7:0]              id_q;
    logic [6:0]              fvp_q;
    logic [W-1:0]            fv_q;
    logic [31:0]             rst_cnt_q, wd_q;
    logic                    armed_q;
    logic [W*NUMRESULTS-1:0] buf_q;
    logic [5:0]              count_q, k_q;
    logic [15:0]             jobs_q;
    logic                    full, push, pop, accept, last;

    // A pop frees a slot in the same cycle, so a full queue still takes a push while IDLE pops.
    assign full      = cnt_q == CW'(FIFO_DEPTH);
    assign pop       = state_q == IDLE && cnt_q != '0;
    assign job_ready = !full || pop;
    assign push      = job_valid && job_ready;
    assign accept    = res_valid && res_ready;

    always_ff @(posedge clock)
        if (push) mem_q[wr_q] <= {job_id, job_fvp, job_firstvalues};

    always_ff @(posedge clock or posedge RESET)
        if (RESET) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end

    always_ff @(posedge clock or posedge RESET)
        if (RESET) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop ? RST : IDLE;
            RST:     state_d = rst_cnt_q == 32'(RST_CYCLES - 1) ? RUN : RST;
            RUN:     state_d = armed_q && asm_done ? SNAP
                             : TIMEOUT_CYCLES != 0 && wd_q == 32'(TIMEOUT_CYCLES - 1) ? TOUT : RUN;
            SNAP:    state_d = DRAIN;
            DRAIN:   state_d = accept && last ? IDLE : DRAIN;
            TOUT:    state_d = accept ? IDLE : TOUT;
            default: state_d = IDLE;
        endcase
    end

    // A done level left over from the previous job is ignored until done is seen low in RUN.
    always_ff @(posedge clock or posedge RESET)
        if (RESET) begin
            id_q      <= '0;
            fvp_q     <= '0;
            fv_q      <= '0;
            rst_cnt_q <= '0;
            wd_q      <= '0;
            armed_q   <= 1'b0;
            buf_q     <= '0;
            count_q   <= '0;
            k_q       <= '0;
            jobs_q    <= '0;
        end else begin
            if (pop) {id_q, fvp_q, fv_q} <= mem_q[rd_q];
            rst_cnt_q <= state_q == RST ? rst_cnt_q + 32'd1 : '0;
            wd_q      <= state_q == RUN ? wd_q + 32'd1 : '0;
            armed_q   <= state_q == RUN && (armed_q || !asm_done);
            if (state_q == SNAP) begin
                buf_q   <= asm_results;
                count_q <= asm_numResults > 6'(NUMRESULTS) ? 6'(NUMRESULTS) : asm_numResults;
                k_q     <= 6'd1;
            end else if (state_q == DRAIN && accept && !last) k_q <= k_q + 6'd1;
            if (accept && last) jobs_q <= jobs_q + 16'd1;
        end

    always_comb begin
        res_valid       = state_q == DRAIN || state_q == TOUT;
        last            = state_q == TOUT || count_q == '0 || k_q == count_q;
        res_last        = res_valid && last;
        res_id          = res_valid ? id_q : '0;
        res_index       = state_q == DRAIN && count_q != '0 ? k_q : '0;
        res_count       = state_q == DRAIN ? count_q : '0;
        res_marks       = state_q == DRAIN && count_q != '0 ? buf_q[(NUMRESULTS - int'(k_q)) * W +: W] : '0;
        res_timeout     = state_q == TOUT;
        asm_reset       = RESET || state_q == RST;
        asm_fvp         = fvp_q;
        asm_firstvalues = fv_q;
        busy            = state_q != IDLE || cnt_q != '0;
        jobs_completed  = jobs_q;
    end
endmodule

// File: tb/tb_ruler_job_scheduler.sv
// tb_ruler_job_scheduler: scoreboard bench for the job scheduler with a small assembly model.
module tb_ruler_job_scheduler;
    localparam int NP = 5;
    localparam int NR = 10;
    localparam int W  = (NP + 1) * 9;
    localparam int RC = 2;
    localparam int TO = 8;

    logic            clock = 1'b0;
    logic            RESET;
    logic            job_valid, job_ready;
    logic [7:0]      job_id;
    logic [6:0]      job_fvp;
    logic [W-1:0]    job_firstvalues;
    logic            asm_reset, asm_done;
    logic [6:0]      asm_fvp;
    logic [W-1:0]    asm_firstvalues;
    logic [5:0]      asm_numResults;
    logic [W*NR-1:0] asm_results;
    logic            res_valid, res_ready, res_last, res_timeout, busy;
    logic [7:0]      res_id;
    logic [5:0]      res_index, res_count;
    logic [W-1:0]    res_marks;
    logic [15:0]     jobs_completed;

    always #5 clock = ~clock;

    ruler_job_scheduler #(
        .NUMPOSITIONS(NP), .NUMRESULTS(NR), .FIFO_DEPTH(4), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .RESET(RESET),
        .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id), .job_fvp(job_fvp),
        .job_firstvalues(job_firstvalues),
        .asm_reset(asm_reset), .asm_fvp(asm_fvp), .asm_firstvalues(asm_firstvalues),
        .asm_done(asm_done), .asm_numResults(asm_numResults), .asm_results(asm_results),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_index(res_index),
        .res_count(res_count), .res_marks(res_marks), .res_last(res_last), .res_timeout(res_timeout),
        .busy(busy), .jobs_completed(jobs_completed)
    );

    typedef struct {
        logic [7:0]   id;
        logic [5:0]   idx;
        logic [5:0]   cnt;
        logic [W-1:0] marks;
        logic         last;
        logic         to;
    } rec_t;

    rec_t sb[$];
    rec_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Assembly model: done rises a few cycles after its reset is released.
    logic auto_en = 1'b0, auto_done = 1'b0, man_done = 1'b0;
    int   mcnt = 0;
    assign asm_done = auto_en ? auto_done : man_done;

    initial forever begin
        @(posedge clock); #1;
        if (auto_en) begin
            if (asm_reset) begin auto_done = 1'b0; mcnt = 0; end
            else if (mcnt == 2) auto_done = 1'b1;
            else mcnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clock)
        if (!RESET && res_valid && res_ready) begin
            check("rec_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("res_id", 64'(res_id), 64'(mon_e.id));
                check("res_index", 64'(res_index), 64'(mon_e.idx));
                check("res_count", 64'(res_count), 64'(mon_e.cnt));
                check("res_marks", 64'(res_marks), 64'(mon_e.marks));
                check("res_last", 64'(res_last), 64'(mon_e.last));
                check("res_timeout", 64'(res_timeout), 64'(mon_e.to));
            end
        end

    function automatic logic [W-1:0] ruler(input int a, b, c, d, e, f);
        return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e), 9'(f)};
    endfunction

    task automatic set_slot(input int k, input logic [W-1:0] v);
        asm_results[(NR - k) * W +: W] = v;
    endtask

    task automatic expect_rec(input logic [7:0] id, input logic [5:0] idx, input logic [5:0] cnt,
                              input logic [W-1:0] m, input logic last, input logic to);
        rec_t r;
        r.id = id; r.idx = idx; r.cnt = cnt; r.marks = m; r.last = last; r.to = to;
        sb.push_back(r);
    endtask

    task automatic push(input logic [7:0] id, input logic [6:0] fvp, input logic [W-1:0] fv);
        int n = 0;
        job_valid = 1'b1; job_id = id; job_fvp = fvp; job_firstvalues = fv;
        #1;
        while (!job_ready && n < 200) begin @(posedge clock); #1; n++; end
        check("push_ready", 64'(job_ready), 64'd1);
        @(posedge clock); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_run(input logic [6:0] fvp, input logic [W-1:0] fv);
        int n = 0, r = 0;
        while (!asm_reset && n < 50) begin @(posedge clock); #1; n++; end
        while (asm_reset && r < 50) begin @(posedge clock); #1; r++; end
        check("rst_len", 64'(r), 64'(RC));
        check("asm_fvp", 64'(asm_fvp), 64'(fvp));
        check("asm_firstvalues", 64'(asm_firstvalues), 64'(fv));
    endtask

    task automatic start_job(input logic [7:0] id, input logic [6:0] fvp, input logic [W-1:0] fv);
        push(id, fvp, fv);
        wait_run(fvp, fv);
    endtask

    task automatic wait_jobs(input int n);
        int c = 0;
        while (jobs_completed != 16'(n) && c < 300) begin @(posedge clock); #1; c++; end
        check("jobs_completed", 64'(jobs_completed), 64'(n));
    endtask

    task automatic wait_valid();
        int c = 0;
        while (!res_valid && c < 100) begin @(posedge clock); #1; c++; end
        check("res_valid_wait", 64'(res_valid), 64'd1);
    endtask

    logic [W-1:0] r1, r2, r3, fv;

    initial begin
        RESET = 1'b1; job_valid = 1'b0; job_id = '0; job_fvp = '0; job_firstvalues = '0;
        asm_numResults = '0; asm_results = '0; res_ready = 1'b1;
        r1 = ruler(0, 1, 4, 10, 12, 17);
        r2 = ruler(0, 1, 8, 11, 13, 17);
        r3 = ruler(0, 3, 4, 9, 15, 17);
        repeat (3) @(posedge clock); #1;
        check("rst_asm_reset", 64'(asm_reset), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_job_ready", 64'(job_ready), 64'd1);
        check("rst_jobs", 64'(jobs_completed), 64'd0);
        check("rst_asm_fvp", 64'(asm_fvp), 64'd0);
        RESET = 1'b0;
        @(posedge clock); #1;
        check("idle_asm_reset", 64'(asm_reset), 64'd0);

        // single job, two results
        set_slot(1, r1); set_slot(2, r2); asm_numResults = 6'd2;
        expect_rec(8'h11, 6'd1, 6'd2, r1, 1'b0, 1'b0);
        expect_rec(8'h11, 6'd2, 6'd2, r2, 1'b1, 1'b0);
        start_job(8'h11, 7'd1, '0);
        @(posedge clock); #1; man_done = 1'b1;
        wait_jobs(1);
        check("busy_idle", 64'(busy), 64'd0);
        man_done = 1'b0;

        // backpressure and done-to-valid latency
        set_slot(3, r3); asm_numResults = 6'd3; res_ready = 1'b0;
        fv = ruler(0, 2, 0, 0, 0, 0);
        expect_rec(8'h22, 6'd1, 6'd3, r1, 1'b0, 1'b0);
        expect_rec(8'h22, 6'd2, 6'd3, r2, 1'b0, 1'b0);
        expect_rec(8'h22, 6'd3, 6'd3, r3, 1'b1, 1'b0);
        start_job(8'h22, 7'd2, fv);
        @(posedge clock); #1; man_done = 1'b1;
        @(posedge clock); #1; check("lat_snap_valid", 64'(res_valid), 64'd0);
        @(posedge clock); #1; check("lat_drain_valid", 64'(res_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(res_valid), 64'd1);
            check("stall_index", 64'(res_index), 64'(sb[0].idx));
            check("stall_marks", 64'(res_marks), 64'(sb[0].marks));
            check("stall_last", 64'(res_last), 64'(sb[0].last));
            @(posedge clock); #1;
        end
        res_ready = 1'b1;
        wait_jobs(2);
        man_done = 1'b0;

        // queue full, push+pop when full, in-order service
        asm_results = '0; set_slot(1, r1); asm_numResults = 6'd1; res_ready = 1'b0; auto_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_rec(8'(i), 6'd1, 6'd1, r1, 1'b1, 1'b0);
            push(8'(i), 7'(i), '0);
        end
        check("full_ready", 64'(job_ready), 64'd0);
        wait_valid();
        expect_rec(8'd5, 6'd1, 6'd1, r1, 1'b1, 1'b0);
        res_ready = 1'b1;
        push(8'd5, 7'd5, '0);
        check("pushpop_full_ready", 64'(job_ready), 64'd0);
        check("pushpop_busy", 64'(busy), 64'd1);
        wait_jobs(8);
        auto_en = 1'b0;

        // stale done must not complete; count clamped to NR
        man_done = 1'b1; asm_numResults = 6'd12;
        for (int k = 1; k <= NR; k++) begin
            set_slot(k, ruler(0, k, 2 * k, 3 * k, 4 * k, 5 * k));
            expect_rec(8'h44, 6'(k), 6'd10, ruler(0, k, 2 * k, 3 * k, 4 * k, 5 * k), 1'(k == NR), 1'b0);
        end
        start_job(8'h44, 7'd3, r2);
        repeat (3) begin @(posedge clock); #1; check("stale_done_no_snap", 64'(res_valid), 64'd0); end
        man_done = 1'b0;
        @(posedge clock); #1; check("done_low_no_snap", 64'(res_valid), 64'd0);
        man_done = 1'b1;
        wait_jobs(9);
        man_done = 1'b0;

        // watchdog timeout, then an empty-result job
        asm_numResults = 6'd0;
        expect_rec(8'h55, 6'd0, 6'd0, '0, 1'b1, 1'b1);
        expect_rec(8'h56, 6'd0, 6'd0, '0, 1'b1, 1'b0);
        push(8'h55, 7'd4, '0);
        push(8'h56, 7'd5, '0);
        wait_jobs(10);
        auto_en = 1'b1;
        wait_jobs(11);
        auto_en = 1'b0;

        // asynchronous reset while draining
        set_slot(1, r1); set_slot(2, r2); set_slot(3, r3); asm_numResults = 6'd3; res_ready = 1'b0;
        start_job(8'h66, 7'd6, r3);
        push(8'h67, 7'd7, '0);
        man_done = 1'b1;
        wait_valid();
        #3 RESET = 1'b1;
        #1;
        check("async_res_valid", 64'(res_valid), 64'd0);
        check("async_asm_reset", 64'(asm_reset), 64'd1);
        check("async_jobs", 64'(jobs_completed), 64'd0);
        sb.delete();
        @(posedge clock); #1;
        RESET = 1'b0; man_done = 1'b0; res_ready = 1'b1;
        repeat (3) @(posedge clock); #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_res_valid", 64'(res_valid), 64'd0);
        check("post_rst_job_ready", 64'(job_ready), 64'd1);
        check("post_rst_asm_reset", 64'(asm_reset), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
